// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1to4_stream
//  Description : Registered 1-to-4 stream demultiplexer. Each channel has a
//                one-entry holding register with its own valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_stream #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    opc,
    input  logic [N-1:0]  x,
    output logic [N-1:0]  y0,
    output logic [N-1:0]  y1,
    output logic [N-1:0]  y2,
    output logic [N-1:0]  y3,
    output logic          v0,
    output logic          v1,
    output logic          v2,
    output logic          v3,
    input  logic          r0,
    input  logic          r1,
    input  logic          r2,
    input  logic          r3,
    output logic [CW-1:0] count
);

    localparam logic [3:0] c_no_load = 4'b0000;
    localparam logic [3:0] c_one_hot = 4'b0001;

    logic [3:0]          r_full;
    logic [3:0][N-1:0]   r_data;
    logic [CW-1:0]       r_count;

    logic [3:0]          w_rdy;
    logic                w_accept;
    logic [3:0]          w_load;

    assign w_rdy    = {r3, r2, r1, r0};

    // A full channel may still take a word when its consumer drains it in the same cycle.
    assign in_ready = ~r_full[opc] | w_rdy[opc];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? (c_one_hot << opc) : c_no_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= x;
                    r_full[k] <= 1'b1;
                end else if (r_full[k] && w_rdy[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign y0    = r_data[0];
    assign y1    = r_data[1];
    assign y2    = r_data[2];
    assign y3    = r_data[3];
    assign v0    = r_full[0];
    assign v1    = r_full[1];
    assign v2    = r_full[2];
    assign v3    = r_full[3];
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1to4_stream
//  Description : Scoreboard bench for demux_1to4_stream with a queue-based
//                channel model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_stream;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    opc;
    logic [N-1:0]  x;
    logic [N-1:0]  y0, y1, y2, y3;
    logic          v0, v1, v2, v3;
    logic          r0, r1, r2, r3;
    logic [CW-1:0] count;
    logic [3:0]    rr;

    demux_1to4_stream #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opc(opc), .x(x),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .count(count)
    );

    always #5 clk = ~clk;

    assign r0 = rr[0];
    assign r1 = rr[1];
    assign r2 = rr[2];
    assign r3 = rr[3];

    logic [3:0]   v_vec;
    logic [N-1:0] y_arr [4];
    assign v_vec = {v3, v2, v1, v0};
    always_comb begin
        y_arr[0] = y0;
        y_arr[1] = y1;
        y_arr[2] = y2;
        y_arr[3] = y3;
    end

    // Reference model: per channel a queue of words still owed to the consumer,
    // the last word delivered to that channel, and the number of accepted words.
    logic [N-1:0] exq [4][$];
    logic [N-1:0] ylast [4];
    int           occ [4];
    int           accepted;
    bit           last_acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exq[k].delete();
            ylast[k] = '0;
            occ[k]   = 0;
        end
        accepted = 0;
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance the model.
    task automatic step(input bit rs, input bit vl, input logic [1:0] oc,
                        input logic [N-1:0] xd, input logic [3:0] rdy);
        bit exp_ready;
        rst      = rs;
        in_valid = vl;
        opc      = oc;
        x        = xd;
        rr       = rdy;
        @(negedge clk);
        exp_ready = (occ[oc] == 0) || rdy[oc];
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("count", 32'(count), 32'(accepted % (1 << CW)));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d", k), 32'(v_vec[k]), 32'(occ[k]));
            check($sformatf("y%0d", k), 32'(y_arr[k]), 32'(ylast[k]));
        end
        last_acc = vl && exp_ready && !rs;
        if (last_acc) exq[oc].push_back(xd);
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (last_acc && (int'(oc) == k)) begin
                    occ[k]   = 1;
                    ylast[k] = xd;
                end else if (occ[k] != 0 && rdy[k]) begin
                    occ[k] = 0;
                end
            end
            if (last_acc) accepted++;
        end
        #1;
    endtask

    // Monitor: every word seen leaving a channel must be the oldest one owed to it.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (v_vec[k] === 1'b1 && rr[k] === 1'b1) begin
                    if (exq[k].size() == 0) begin
                        check($sformatf("drain%0d_unexpected", k), 32'(1), 32'(0));
                    end else begin
                        check($sformatf("drain%0d_data", k), 32'(y_arr[k]), 32'(exq[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          pend;
        logic        vl;
        logic [1:0]  oc;
        logic [N-1:0] xd;

        rst = 1'b1; in_valid = 1'b0; opc = '0; x = '0; rr = 4'hF;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held while a word is presented
        step(1'b1, 1'b1, 2'd0, 8'hAA, 4'hF);
        step(1'b1, 1'b1, 2'd0, 8'hAA, 4'hF);

        // Basic routing
        step(1'b0, 1'b1, 2'd0, 8'h11, 4'hF);
        step(1'b0, 1'b1, 2'd1, 8'h22, 4'hF);
        step(1'b0, 1'b1, 2'd2, 8'h33, 4'hF);
        step(1'b0, 1'b1, 2'd3, 8'h44, 4'hF);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // Backpressure isolation on channel 2
        step(1'b0, 1'b1, 2'd2, 8'h5A, 4'b1011);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2, 8'hC3, 4'b1011);
        step(1'b0, 1'b1, 2'd1, 8'h77, 4'b1011);
        step(1'b0, 1'b1, 2'd2, 8'hC3, 4'hF);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // Simultaneous drain and load on channel 3, back to back
        step(1'b0, 1'b1, 2'd3, 8'h01, 4'hF);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'd3, 8'(8'h02 + i), 4'hF);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // Counter wrap: 17 words on rotating channels
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 2'(i), 8'($urandom), 4'hF);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // Reset mid-operation with every channel full and stalled
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 8'(8'hE0 + i), 4'h0);
        step(1'b0, 1'b1, 2'd1, 8'hEE, 4'h0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        step(1'b0, 1'b1, 2'd0, 8'h99, 4'h0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // Randomized traffic obeying the producer hold rule
        pend = 1'b0; vl = 1'b0; oc = '0; xd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                vl = ($urandom_range(0, 3) != 0);
                oc = 2'($urandom);
                xd = 8'($urandom);
            end
            step(1'b0, vl, oc, xd, 4'($urandom));
            pend = vl && !last_acc;
        end

        // Drain everything and confirm nothing is left owed
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("leftover%0d", k), 32'(exq[k].size()), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
